// File: rtl/mod8_wrap_monitor.sv
// Checker for a 3-bit MOD-8 down counter: follows the 7..0 sequence, counts
// completed periods and logs wrap / sequence-error events into a small FIFO.
module mod8_wrap_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  count,
  input  logic                        clear,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [WRAP_W+1:0]           evt_data,
  output logic [WRAP_W-1:0]           wrap_count,
  output logic                        seq_error,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {SYNC, LOCKED} state_t;

  state_t              state, state_n;
  logic [2:0]          prev, prev_n, expected;
  logic [WRAP_W-1:0]   wrap_n;
  logic                push, push_ok, pop, full, seq_set;
  logic [WRAP_W+1:0]   push_data;
  logic [WRAP_W+1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;

  assign expected  = prev - 3'd1;
  assign evt_valid = (fifo_level != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid && evt_ready;
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);

  always_comb begin
    state_n   = state;
    prev_n    = prev;
    wrap_n    = wrap_count;
    push      = 1'b0;
    push_data = '0;
    seq_set   = 1'b0;
    case (state)
      SYNC: begin
        prev_n  = count;
        state_n = LOCKED;
      end
      LOCKED: begin
        if (count == expected) begin
          prev_n = count;
          if (prev == 3'd0) begin
            wrap_n    = wrap_count + 1'b1;
            push      = 1'b1;
            push_data = {2'b01, wrap_n};
          end
        end else begin
          push      = 1'b1;
          push_data = {2'b10, wrap_count};
          seq_set   = 1'b1;
          state_n   = SYNC;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // Clear outranks every other update; FIFO contents are simply abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      prev       <= '0;
      wrap_count <= '0;
      seq_error  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      state      <= SYNC;
      wrap_count <= '0;
      seq_error  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      wrap_count <= wrap_n;
      if (seq_set) seq_error <= 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop) fifo_level <= fifo_level + LW'(1);
      else if (!push_ok && pop) fifo_level <= fifo_level - LW'(1);
    end
  end

endmodule

// File: tb/tb_mod8_wrap_monitor.sv
// Directed bench for mod8_wrap_monitor: wraps, sequence errors, FIFO
// overflow / simultaneous push-pop, narrow wrap counter, clear and async reset.
module tb_mod8_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ready3 = 1'b1;
  logic [2:0] count = 3'd0;
  logic [2:0] cnt = 3'd7;

  logic       evt_valid, seq_error, overflow;
  logic [9:0] evt_data;
  logic [7:0] wrap_count;
  logic [2:0] fifo_level;

  logic       evt_valid3, seq_error3, overflow3;
  logic [4:0] evt_data3;
  logic [2:0] wrap_count3;
  logic [2:0] fifo_level3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mod8_wrap_monitor #(.FIFO_DEPTH(4), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .count(count), .clear(clear), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_data(evt_data), .wrap_count(wrap_count),
    .seq_error(seq_error), .overflow(overflow), .fifo_level(fifo_level)
  );

  mod8_wrap_monitor #(.FIFO_DEPTH(4), .WRAP_W(3)) dut3 (
    .clk(clk), .reset(reset), .count(count), .clear(clear), .evt_ready(ready3),
    .evt_valid(evt_valid3), .evt_data(evt_data3), .wrap_count(wrap_count3),
    .seq_error(seq_error3), .overflow(overflow3), .fifo_level(fifo_level3)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one sample and return 1 time unit after the capturing edge.
  task automatic apply_stimulus(input logic [2:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic count_step();
    apply_stimulus(cnt);
    cnt = cnt - 3'd1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cnt = 3'd7;
  endtask

  initial begin
    // Reset values while reset is held
    reset = 1'b1;
    #2;
    check_output("rst_valid", 32'(evt_valid), 32'd0);
    check_output("rst_data", 32'(evt_data), 32'd0);
    check_output("rst_wrap", 32'(wrap_count), 32'd0);
    check_output("rst_seq", 32'(seq_error), 32'd0);
    check_output("rst_ovf", 32'(overflow), 32'd0);
    check_output("rst_level", 32'(fifo_level), 32'd0);
    reset = 1'b0;
    cnt = 3'd7;
    evt_ready = 1'b1;

    // Free-running counter: wraps land on edges 9 and 17
    for (int k = 1; k <= 20; k++) begin
      count_step();
      check_output("run_valid", 32'(evt_valid), 32'(k == 9 || k == 17));
      if (k == 9)  check_output("run_wrap1", 32'(evt_data), 32'h101);
      if (k == 17) check_output("run_wrap2", 32'(evt_data), 32'h102);
    end
    check_output("run_wrapcnt", 32'(wrap_count), 32'd2);
    check_output("run_seq", 32'(seq_error), 32'd0);

    // Sequence error: 101 -> 010 after a third wrap
    for (int k = 0; k < 7; k++) count_step();
    check_output("pre_err_wrap", 32'(wrap_count), 32'd3);
    apply_stimulus(3'd2);
    check_output("err_valid", 32'(evt_valid), 32'd1);
    check_output("err_data", 32'(evt_data), 32'h203);
    check_output("err_seq", 32'(seq_error), 32'd1);
    check_output("err_wrap", 32'(wrap_count), 32'd3);
    apply_stimulus(3'd1);
    check_output("resync_valid", 32'(evt_valid), 32'd0);
    apply_stimulus(3'd0);
    check_output("resync_noerr", 32'(evt_valid), 32'd0);
    apply_stimulus(3'd7);
    check_output("resync_wrap_valid", 32'(evt_valid), 32'd1);
    check_output("resync_wrap_data", 32'(evt_data), 32'h104);
    check_output("resync_wrapcnt", 32'(wrap_count), 32'd4);

    // Overflow: six wraps with the consumer stalled
    pulse_reset();
    evt_ready = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      count_step();
      if (k == 33) begin
        check_output("ovf_full_level", 32'(fifo_level), 32'd4);
        check_output("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    check_output("ovf_level", 32'(fifo_level), 32'd4);
    check_output("ovf_flag", 32'(overflow), 32'd1);
    check_output("ovf_wrapcnt", 32'(wrap_count), 32'd6);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_output("drain_data", 32'(evt_data), 32'h100 + 32'(i));
      count_step();
    end
    check_output("drain_valid", 32'(evt_valid), 32'd0);
    check_output("drain_level", 32'(fifo_level), 32'd0);

    // Full FIFO with a pop on the cycle of the fifth wrap
    pulse_reset();
    evt_ready = 1'b0;
    for (int k = 1; k <= 40; k++) count_step();
    check_output("pp_pre_level", 32'(fifo_level), 32'd4);
    evt_ready = 1'b1;
    count_step();
    check_output("pp_level", 32'(fifo_level), 32'd4);
    check_output("pp_ovf", 32'(overflow), 32'd0);
    check_output("pp_head", 32'(evt_data), 32'h102);
    for (int i = 2; i <= 5; i++) begin
      check_output("pp_drain", 32'(evt_data), 32'h100 + 32'(i));
      count_step();
    end
    check_output("pp_empty", 32'(evt_valid), 32'd0);

    // Narrow wrap counter rolls over on the 8th wrap
    pulse_reset();
    evt_ready = 1'b1;
    for (int k = 1; k <= 73; k++) begin
      count_step();
      if (k > 1 && (k % 8) == 1) begin
        check_output("w3_valid", 32'(evt_valid3), 32'd1);
        check_output("w3_data", 32'(evt_data3), 32'h8 + 32'(((k - 1) / 8) % 8));
      end
    end
    check_output("w3_wrapcnt", 32'(wrap_count3), 32'd1);

    // Clear on the cycle of a wrap, then asynchronous reset mid-run
    pulse_reset();
    evt_ready = 1'b0;
    for (int k = 1; k <= 48; k++) count_step();
    check_output("clr_pre_ovf", 32'(overflow), 32'd1);
    clear = 1'b1;
    count_step();
    clear = 1'b0;
    check_output("clr_level", 32'(fifo_level), 32'd0);
    check_output("clr_wrap", 32'(wrap_count), 32'd0);
    check_output("clr_ovf", 32'(overflow), 32'd0);
    check_output("clr_seq", 32'(seq_error), 32'd0);
    check_output("clr_valid", 32'(evt_valid), 32'd0);
    count_step();
    check_output("clr_sync_valid", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 7; k++) count_step();
    check_output("post_clr_wrap", 32'(wrap_count), 32'd1);
    check_output("post_clr_valid", 32'(evt_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_output("async_valid", 32'(evt_valid), 32'd0);
    check_output("async_data", 32'(evt_data), 32'd0);
    check_output("async_wrap", 32'(wrap_count), 32'd0);
    check_output("async_level", 32'(fifo_level), 32'd0);
    check_output("async_seq", 32'(seq_error), 32'd0);
    check_output("async_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mod8_wrap_monitor.md
# mod8_wrap_monitor

Downstream checker and event logger for the 3-bit MOD-8 down counter. Samples the counter's `count` output every clock, checks that it follows the legal 111→110→…→000→111 sequence, counts completed periods (000→111 wraps) and logs wrap and sequence-error events into a small FIFO. Software or a test harness drains the FIFO over a valid/ready interface.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, ≥2.
- `WRAP_W`, 8: width of the wrap counter and of the event payload.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `count`  in  3  counter value under observation, sampled every rising edge.
- `clear`  in  1  synchronous clear: flush FIFO, zero `wrap_count`, clear sticky flags, FSM→SYNC.
- `evt_ready`  in  1  consumer accepts head event.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  WRAP_W+2  head event: [WRAP_W+1:WRAP_W] type (2'b01 wrap, 2'b10 sequence error), [WRAP_W-1:0] wrap_count snapshot.
- `wrap_count`  out  WRAP_W  completed periods, modulo 2^WRAP_W.
- `seq_error`  out  1  sticky: any sequence mismatch seen.
- `overflow`  out  1  sticky: an event was dropped on a full FIFO.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Reset values: `evt_valid`=0, `evt_data`=0, `wrap_count`=0, `seq_error`=0, `overflow`=0, `fifo_level`=0, FSM=SYNC, `prev`=0.
- Internal register `prev[2:0]` holds the previous sample.
- FSM states:
  - SYNC: `prev`←`count`; no check, no event; next state LOCKED.
  - LOCKED: `expected` = (`prev` − 1) mod 8 (3-bit wrap, so 000 → 111).
    - `count`==`expected`, `prev`==000: wrap. `wrap_count`←`wrap_count`+1 (wraps to 0 past 2^WRAP_W−1); push {01, new wrap_count}.
    - `count`==`expected`, other `prev`: no event.
    - `count`≠`expected`: push {10, current wrap_count}; `seq_error`←1; next state SYNC. `wrap_count` is unchanged.
    - In both matching cases `prev`←`count`.
- Held value (`count`==`prev`) is a mismatch.
- FIFO:
  - Push is accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the event is dropped and `overflow`←1.
  - Pop when `evt_valid` && `evt_ready`.
  - `evt_data` is the registered head entry. It is stable while `evt_valid` && !`evt_ready`.
  - `evt_data` value when empty is don't-care; the bench must not check it.
- `clear` has priority over push, pop, wrap increment and error set in the same cycle. Effects are visible after the edge.
- `reset` asserted mid-operation: all outputs go to their reset values immediately (asynchronous); events held in the FIFO are lost.

## Timing
- Check latency: a `count` value sampled at edge N is compared against `prev`. The resulting event appears at the FIFO head, `evt_valid`=1, after edge N if the FIFO was empty.
- `wrap_count`, `seq_error` and `overflow` update at the same edge N.
- First edge after reset release: SYNC, sample only. The checks run from the second edge onward.
- After a mismatch at edge N, edge N+1 is SYNC (no check). Checking resumes at edge N+2.
- Throughput: one push and one pop per cycle. `fifo_level` reflects both at the same edge.

## Test plan
- Reset release with a free-running counter starting at 111 for 20 edges → events {01,1} at the 9th edge and {01,2} at the 17th; `seq_error`=0; no other events.
- Force `count` 101→010 mid-sequence → event {10,wrap_count}, `seq_error`=1. The next sample is unchecked; the sequence continuing from 010 (001, 000, 111) then gives a wrap event with no further error.
- `evt_ready`=0, FIFO_DEPTH=4, six wraps → `fifo_level`=4 and `overflow`=1. Draining returns wrap counts 1,2,3,4 in order, then `evt_valid`=0.
- FIFO full with `evt_ready`=1 on the cycle of a fifth wrap → no overflow, `fifo_level` stays 4, the new entry is at the tail.
- WRAP_W=3 with nine wraps → the 8th wrap event carries payload 0, the 9th carries 1; `wrap_count`=1.
- `clear` pulse coinciding with a wrap, then async `reset` mid-run → after clear: level 0, `wrap_count`=0, flags 0, no event logged. Reset: all outputs 0 without waiting for a clock edge.
